control_unit: RTL
=================

Name: control_unit

Overview:
- Hardwired control sequencer that sits directly upstream of the CPU datapath top level.
- Consumes the instruction register contents and the CON flip-flop result.
- Produces, cycle by cycle, every register-transfer strobe the datapath takes as input: the register select/enable lines, bus-drive lines, ALU select and memory strobes.
- Implements fetch plus a fixed step sequence per opcode class, with run/halt control.

Parameters:
- T_STEPS, 8, number of control steps per instruction (T0..T7); fixed, documented for the bench only.

Ports:
- clk  in  1  system clock; all state changes on rising edge
- clr  in  1  reset, synchronous, active-high
- ir  in  32  IR contents; opcode = ir[31:27]
- con  in  1  CON flip-flop output
- stop  in  1  request halt at next instruction boundary
- run  out  1  high while sequencing instructions
- Gra, Grb, Grc, Rin, Rout, BAout, Cout  out  1 each  register-file select/enable lines
- PCout, MDRout, HIout, LOout, ZLowout, ZHighout, InPortout  out  1 each  bus drivers
- PCin, IncPC, IRin, MARin, MDRin, MDRread, memWrite, Yin, Zin, HIin, LOin, conIn, outPortin  out  1 each  register loads and memory strobes
- ALUselect  out  4  ALU operation code

Behaviour:
- States: RESET, T0..T7, HALT. Outputs are decoded combinationally from the current state and ir[31:27]. Any output not listed for a step is 0.
- Reset:
  - clr=1 at an edge puts the FSM in RESET, from any state, including mid-instruction. The partial instruction is abandoned.
  - In RESET all outputs are 0 and run=0.
  - The next edge with clr=0 goes to T0.
- Fetch:
  - T0: PCout, MARin, IncPC.
  - T1: MDRread, MDRin.
  - T2: MDRout, IRin.
  - ir is stable from T3 onward.
- ALU reg-reg (add sub and or shr shl ror rol):
  - T3: Grb, Rout, Yin.
  - T4: Grc, Rout, Zin, ALUselect=op.
  - T5: ZLowout, Gra, Rin.
- Immediate (addi andi ori):
  - T3: Grb, Rout, Yin.
  - T4: Cout, Zin, ALUselect=op.
  - T5: ZLowout, Gra, Rin.
- ldi:
  - T3: Grb, BAout, Yin.
  - T4: Cout, Zin, ALU_ADD.
  - T5: ZLowout, Gra, Rin.
- ld:
  - T3–T4 as ldi.
  - T5: ZLowout, MARin.
  - T6: MDRread, MDRin.
  - T7: MDRout, Gra, Rin.
- st:
  - T3–T5 as ld.
  - T6: Gra, Rout, MDRin (MDRread=0).
  - T7: memWrite.
- mul/div:
  - T3: Gra, Rout, Yin.
  - T4: Grb, Rout, Zin, ALUselect=op.
  - T5: ZLowout, LOin.
  - T6: ZHighout, HIin.
- neg/not:
  - T3: Grb, Rout, Zin, ALUselect=op.
  - T4: ZLowout, Gra, Rin.
- br:
  - T3: Gra, Rout, conIn.
  - T4: PCout, Yin.
  - T5: Cout, Zin, ALU_ADD.
  - T6: if con=1, ZLowout and PCin; else no strobes.
  - con is sampled only in T6.
- jr: T3: Gra, Rout, PCin.
- jal:
  - T3: PCout, Grb, Rin (link).
  - T4: Gra, Rout, PCin.
- in: T3: InPortout, Gra, Rin.
- out: T3: Gra, Rout, outPortin.
- mfhi: T3: HIout, Gra, Rin.
- mflo: T3: LOout, Gra, Rin.
- nop and undefined opcodes: return to T0 after T2.
- End of instruction:
  - The last listed step transitions to T0, or to HALT if stop=1 sampled in that final step.
  - stop at any other time is latched and honoured at the end of the instruction.
- halt opcode: T3 goes to HALT.
- HALT: all outputs 0, run=0; exit only via clr.
- run=1 in T0..T7, 0 in RESET/HALT.
- Invariants: never more than one bus driver active per cycle; Rin and Rout never both high.

Decomposition:
- Shared package cpu_defs_pkg holds:
  - opcode constants: ld=0 ldi=1 st=2 add=3 sub=4 and=5 or=6 shr=7 shl=8 ror=9 rol=10 addi=11 andi=12 ori=13 mul=14 div=15 neg=16 not=17 br=18 jr=19 jal=20 in=21 out=22 mfhi=23 mflo=24 nop=25 halt=26
  - ALU codes: ADD=0 SUB=1 AND=2 OR=3 SHR=4 SHL=5 ROR=6 ROL=7 MUL=8 DIV=9 NEG=10 NOT=11
  - state enum
- One sub-module is natural: op_class_decode, combinational opcode to class plus ALU code.

Test Plan:
- Reset then add (ir=0x18A20000): T0 PCout/MARin/IncPC, T1 MDRread/MDRin, T2 MDRout/IRin, T3 Grb/Rout/Yin, T4 Grc/Rout/Zin/ALUselect=0, T5 ZLowout/Gra/Rin, then back to T0 on the 7th edge.
- st opcode 2: T6 Gra/Rout/MDRin with MDRread=0, T7 memWrite=1 for exactly one cycle, then T0.
- br with con=0 vs con=1: T6 shows no strobes vs ZLowout+PCin; identical T3–T5 in both runs.
- mul opcode 14: T5 ZLowout+LOin, T6 ZHighout+HIin, ALUselect=8 in T4.
- stop pulsed during T4 of an add: instruction completes T5, then HALT, run=0; further clocks idle; clr=1 returns to RESET then T0.
- clr asserted during T6 of ld: next cycle RESET with all outputs 0, then T0; undefined opcode 31 completes after T2 as nop.

Source files
------------

// File: rtl/cpu_defs_pkg.sv
// Shared definitions for the hardwired control sequencer.
// Holds opcode and ALU operation codes, the sequencer state and
// opcode-class enums, and small helpers for stepping through the
// T0..T7 control sequence.
package cpu_defs_pkg;

  // Number of control steps per instruction (T0..T7).
  localparam int unsigned T_STEPS = 8;

  // Opcodes (ir[31:27])
  localparam logic [4:0] OpLd   = 5'd0;
  localparam logic [4:0] OpLdi  = 5'd1;
  localparam logic [4:0] OpSt   = 5'd2;
  localparam logic [4:0] OpAdd  = 5'd3;
  localparam logic [4:0] OpSub  = 5'd4;
  localparam logic [4:0] OpAnd  = 5'd5;
  localparam logic [4:0] OpOr   = 5'd6;
  localparam logic [4:0] OpShr  = 5'd7;
  localparam logic [4:0] OpShl  = 5'd8;
  localparam logic [4:0] OpRor  = 5'd9;
  localparam logic [4:0] OpRol  = 5'd10;
  localparam logic [4:0] OpAddi = 5'd11;
  localparam logic [4:0] OpAndi = 5'd12;
  localparam logic [4:0] OpOri  = 5'd13;
  localparam logic [4:0] OpMul  = 5'd14;
  localparam logic [4:0] OpDiv  = 5'd15;
  localparam logic [4:0] OpNeg  = 5'd16;
  localparam logic [4:0] OpNot  = 5'd17;
  localparam logic [4:0] OpBr   = 5'd18;
  localparam logic [4:0] OpJr   = 5'd19;
  localparam logic [4:0] OpJal  = 5'd20;
  localparam logic [4:0] OpIn   = 5'd21;
  localparam logic [4:0] OpOut  = 5'd22;
  localparam logic [4:0] OpMfhi = 5'd23;
  localparam logic [4:0] OpMflo = 5'd24;
  localparam logic [4:0] OpNop  = 5'd25;
  localparam logic [4:0] OpHalt = 5'd26;

  // ALU operation codes
  localparam logic [3:0] AluAdd = 4'd0;
  localparam logic [3:0] AluSub = 4'd1;
  localparam logic [3:0] AluAnd = 4'd2;
  localparam logic [3:0] AluOr  = 4'd3;
  localparam logic [3:0] AluShr = 4'd4;
  localparam logic [3:0] AluShl = 4'd5;
  localparam logic [3:0] AluRor = 4'd6;
  localparam logic [3:0] AluRol = 4'd7;
  localparam logic [3:0] AluMul = 4'd8;
  localparam logic [3:0] AluDiv = 4'd9;
  localparam logic [3:0] AluNeg = 4'd10;
  localparam logic [3:0] AluNot = 4'd11;

  typedef enum logic [3:0] {
    StReset,
    StT0,
    StT1,
    StT2,
    StT3,
    StT4,
    StT5,
    StT6,
    StT7,
    StHalt
  } state_e;

  // Opcode classes sharing one step sequence.
  typedef enum logic [3:0] {
    ClsNop,
    ClsAlu,
    ClsImm,
    ClsLdi,
    ClsLd,
    ClsSt,
    ClsMulDiv,
    ClsUnary,
    ClsBr,
    ClsJr,
    ClsJal,
    ClsIn,
    ClsOut,
    ClsMfhi,
    ClsMflo,
    ClsHalt
  } op_class_e;

  // Final control step of each class; the instruction ends after it.
  function automatic state_e last_step(op_class_e cls);
    state_e s;
    case (cls)
      ClsNop:                        s = StT2;
      ClsAlu, ClsImm, ClsLdi:        s = StT5;
      ClsLd, ClsSt:                  s = StT7;
      ClsMulDiv, ClsBr:              s = StT6;
      ClsUnary, ClsJal:              s = StT4;
      ClsJr, ClsIn, ClsOut,
      ClsMfhi, ClsMflo, ClsHalt:     s = StT3;
      default:                       s = StT2;
    endcase
    return s;
  endfunction

  // Successor within the T0..T7 sequence.
  function automatic state_e next_step(state_e s);
    state_e n;
    case (s)
      StT0:    n = StT1;
      StT1:    n = StT2;
      StT2:    n = StT3;
      StT3:    n = StT4;
      StT4:    n = StT5;
      StT5:    n = StT6;
      StT6:    n = StT7;
      default: n = StReset;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/op_class_decode.sv
// Combinational opcode decoder.
// Ports:
//   opcode   in  5  ir[31:27]
//   op_class out 4  op_class_e value selecting the step sequence
//   alu_code out 4  ALU operation for the class's ALU step
// Undefined opcodes decode as ClsNop.
module op_class_decode
  import cpu_defs_pkg::*;
(
  input  logic [4:0] opcode,
  output logic [3:0] op_class,
  output logic [3:0] alu_code
);

  op_class_e cls;

  always_comb begin
    cls      = ClsNop;
    alu_code = AluAdd;
    case (opcode)
      OpLd:   cls = ClsLd;
      OpLdi:  cls = ClsLdi;
      OpSt:   cls = ClsSt;
      OpAdd:  begin cls = ClsAlu;    alu_code = AluAdd; end
      OpSub:  begin cls = ClsAlu;    alu_code = AluSub; end
      OpAnd:  begin cls = ClsAlu;    alu_code = AluAnd; end
      OpOr:   begin cls = ClsAlu;    alu_code = AluOr;  end
      OpShr:  begin cls = ClsAlu;    alu_code = AluShr; end
      OpShl:  begin cls = ClsAlu;    alu_code = AluShl; end
      OpRor:  begin cls = ClsAlu;    alu_code = AluRor; end
      OpRol:  begin cls = ClsAlu;    alu_code = AluRol; end
      OpAddi: begin cls = ClsImm;    alu_code = AluAdd; end
      OpAndi: begin cls = ClsImm;    alu_code = AluAnd; end
      OpOri:  begin cls = ClsImm;    alu_code = AluOr;  end
      OpMul:  begin cls = ClsMulDiv; alu_code = AluMul; end
      OpDiv:  begin cls = ClsMulDiv; alu_code = AluDiv; end
      OpNeg:  begin cls = ClsUnary;  alu_code = AluNeg; end
      OpNot:  begin cls = ClsUnary;  alu_code = AluNot; end
      OpBr:   cls = ClsBr;
      OpJr:   cls = ClsJr;
      OpJal:  cls = ClsJal;
      OpIn:   cls = ClsIn;
      OpOut:  cls = ClsOut;
      OpMfhi: cls = ClsMfhi;
      OpMflo: cls = ClsMflo;
      OpHalt: cls = ClsHalt;
      default: cls = ClsNop;
    endcase
  end

  assign op_class = cls;

endmodule

// File: rtl/control_unit.sv
// Hardwired control sequencer for the CPU datapath.
// Steps through fetch (T0..T2) and a per-class execute sequence (T3..T7),
// decoding every datapath strobe combinationally from the state and opcode.
// Ports:
//   clk, clr        clock; synchronous active-high reset
//   ir[31:0], con   instruction register, CON flip-flop
//   stop            halt request, honoured at the next instruction boundary
//   run             high in T0..T7
//   Gra..Cout       register-file select/enable lines
//   PCout..InPortout bus drivers
//   PCin..outPortin register loads and memory strobes
//   ALUselect[3:0]  ALU operation
module control_unit
  import cpu_defs_pkg::*;
(
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] ir,
  input  logic        con,
  input  logic        stop,
  output logic        run,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rin,
  output logic        Rout,
  output logic        BAout,
  output logic        Cout,
  output logic        PCout,
  output logic        MDRout,
  output logic        HIout,
  output logic        LOout,
  output logic        ZLowout,
  output logic        ZHighout,
  output logic        InPortout,
  output logic        PCin,
  output logic        IncPC,
  output logic        IRin,
  output logic        MARin,
  output logic        MDRin,
  output logic        MDRread,
  output logic        memWrite,
  output logic        Yin,
  output logic        Zin,
  output logic        HIin,
  output logic        LOin,
  output logic        conIn,
  output logic        outPortin,
  output logic [3:0]  ALUselect
);

  state_e     state_q;
  logic       stop_pend_q;
  logic [3:0] op_class_raw;
  logic [3:0] alu_code;
  op_class_e  cls;
  logic       at_last;
  logic       unused_ir;

  op_class_decode u_decode (
    .opcode   (ir[31:27]),
    .op_class (op_class_raw),
    .alu_code (alu_code)
  );

  assign cls       = op_class_e'(op_class_raw);
  assign unused_ir = ^ir[26:0];

  // The nop/undefined early exit at T2 relies on ir already showing the new
  // opcode during T2; for all other classes the decision is taken from T3 on.
  assign at_last = (state_q == last_step(cls));
  assign run     = (state_q != StReset) && (state_q != StHalt);

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q     <= StReset;
      stop_pend_q <= 1'b0;
    end else begin
      case (state_q)
        StReset: state_q <= StT0;
        StHalt:  state_q <= StHalt;
        default: begin
          if (at_last) begin
            if (cls == ClsHalt || stop || stop_pend_q) state_q <= StHalt;
            else                                         state_q <= StT0;
            stop_pend_q <= 1'b0;
          end else begin
            state_q     <= next_step(state_q);
            stop_pend_q <= stop_pend_q | stop;
          end
        end
      endcase
    end
  end

  always_comb begin
    Gra = 1'b0; Grb = 1'b0; Grc = 1'b0; Rin = 1'b0; Rout = 1'b0;
    BAout = 1'b0; Cout = 1'b0;
    PCout = 1'b0; MDRout = 1'b0; HIout = 1'b0; LOout = 1'b0;
    ZLowout = 1'b0; ZHighout = 1'b0; InPortout = 1'b0;
    PCin = 1'b0; IncPC = 1'b0; IRin = 1'b0; MARin = 1'b0; MDRin = 1'b0;
    MDRread = 1'b0; memWrite = 1'b0; Yin = 1'b0; Zin = 1'b0;
    HIin = 1'b0; LOin = 1'b0; conIn = 1'b0; outPortin = 1'b0;
    ALUselect = AluAdd;

    case (state_q)
      StT0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; end
      StT1: begin MDRread = 1'b1; MDRin = 1'b1; end
      StT2: begin MDRout = 1'b1; IRin = 1'b1; end
      StT3: begin
        case (cls)
          ClsAlu, ClsImm: begin Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; end
          ClsLdi, ClsLd, ClsSt: begin Grb = 1'b1; BAout = 1'b1; Yin = 1'b1; end
          ClsMulDiv: begin Gra = 1'b1; Rout = 1'b1; Yin = 1'b1; end
          ClsUnary: begin
            Grb = 1'b1; Rout = 1'b1; Zin = 1'b1; ALUselect = alu_code;
          end
          ClsBr:   begin Gra = 1'b1; Rout = 1'b1; conIn = 1'b1; end
          ClsJr:   begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
          ClsJal:  begin PCout = 1'b1; Grb = 1'b1; Rin = 1'b1; end
          ClsIn:   begin InPortout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          ClsOut:  begin Gra = 1'b1; Rout = 1'b1; outPortin = 1'b1; end
          ClsMfhi: begin HIout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          ClsMflo: begin LOout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          default: ;
        endcase
      end
      StT4: begin
        case (cls)
          ClsAlu: begin
            Grc = 1'b1; Rout = 1'b1; Zin = 1'b1; ALUselect = alu_code;
          end
          ClsImm: begin Cout = 1'b1; Zin = 1'b1; ALUselect = alu_code; end
          ClsLdi, ClsLd, ClsSt: begin Cout = 1'b1; Zin = 1'b1; ALUselect = AluAdd; end
          ClsMulDiv: begin
            Grb = 1'b1; Rout = 1'b1; Zin = 1'b1; ALUselect = alu_code;
          end
          ClsUnary: begin ZLowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          ClsBr:    begin PCout = 1'b1; Yin = 1'b1; end
          ClsJal:   begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
          default: ;
        endcase
      end
      StT5: begin
        case (cls)
          ClsAlu, ClsImm, ClsLdi: begin ZLowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          ClsLd, ClsSt: begin ZLowout = 1'b1; MARin = 1'b1; end
          ClsMulDiv:    begin ZLowout = 1'b1; LOin = 1'b1; end
          ClsBr:        begin Cout = 1'b1; Zin = 1'b1; ALUselect = AluAdd; end
          default: ;
        endcase
      end
      StT6: begin
        case (cls)
          ClsLd:     begin MDRread = 1'b1; MDRin = 1'b1; end
          // Store data comes from the register file, not memory.
          ClsSt:     begin Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1; end
          ClsMulDiv: begin ZHighout = 1'b1; HIin = 1'b1; end
          ClsBr: begin
            if (con) begin ZLowout = 1'b1; PCin = 1'b1; end
          end
          default: ;
        endcase
      end
      StT7: begin
        case (cls)
          ClsLd:   begin MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          ClsSt:   memWrite = 1'b1;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule
